// File: rtl/vga_sync_gen.sv
// Raster timing generator: nested horizontal/vertical wrap counters, with registered sync
// and blanking outputs decoded from the next counter values, plus line and frame strobes.
module vga_sync_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic [9:0]        hpos,
  output logic [9:0]        vpos,
  output logic              line_end,
  output logic              frame_end,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_VISIBLE);
  localparam logic [10:0] V_ACT    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  // Half-open window test; bounds carry an extra bit so a total of 1024 still fits.
  function automatic logic in_window(input logic [9:0] pos, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  logic [9:0]        hpos_nxt;
  logic [9:0]        vpos_nxt;
  logic [FCNT_W-1:0] fcnt_nxt;

  assign line_end  = pix_en && (hpos == H_LAST);
  assign frame_end = line_end && (vpos == V_LAST);

  // Next-state counters; the >= compares keep any stray value from escaping its range
  always_comb begin
    hpos_nxt = hpos;
    vpos_nxt = vpos;
    fcnt_nxt = frame_cnt;
    if (pix_en) begin
      if (hpos >= H_LAST) begin
        hpos_nxt = '0;
        if (vpos >= V_LAST) begin
          vpos_nxt = '0;
          fcnt_nxt = frame_cnt + 1'b1;
        end else begin
          vpos_nxt = vpos + 10'd1;
        end
      end else begin
        hpos_nxt = hpos + 10'd1;
      end
    end
  end

  // Register stage: sync and blanking decoded from next values so they align with hpos/vpos
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos       <= '0;
      vpos       <= '0;
      frame_cnt  <= '0;
      display_on <= 1'b1;
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
    end else begin
      hpos       <= hpos_nxt;
      vpos       <= vpos_nxt;
      frame_cnt  <= fcnt_nxt;
      display_on <= ({1'b0, hpos_nxt} < H_ACT) && ({1'b0, vpos_nxt} < V_ACT);
      hsync      <= sync_level(in_window(hpos_nxt, HS_START, HS_END), HS_POL);
      vsync      <= sync_level(in_window(vpos_nxt, VS_START, VS_END), VS_POL);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using small raster timing; the reference model tracks a linear
// pixel index within the frame and derives coordinates and sync levels arithmetically.
module tb_vga_sync_gen;

  localparam int   HV = 8, HF = 1, HS = 2, HB = 1;
  localparam int   VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int   HT = HV + HF + HS + HB;
  localparam int   VT = VV + VF + VS + VB;
  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b1;
  localparam int   FCNT_W = 8;
  localparam int   FRAME  = HT * VT;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pix_en = 1'b0;
  logic              hsync, vsync, display_on, line_end, frame_end;
  logic [9:0]        hpos, vpos;
  logic [FCNT_W-1:0] frame_cnt;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .line_end(line_end), .frame_end(frame_end),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pix    = 0;
  int fcnt   = 0;
  bit known  = 0;
  int fe_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    int h, v;
    h = pix % HT;
    v = pix / HT;
    check("hpos", 32'(hpos), 32'(h));
    check("vpos", 32'(vpos), 32'(v));
    check("display_on", 32'(display_on), 32'(h < HV && v < VV));
    check("hsync", 32'(hsync),
          32'((h >= HV + HF && h < HV + HF + HS) ? HS_POL : !HS_POL));
    check("vsync", 32'(vsync),
          32'((v >= VV + VF && v < VV + VF + VS) ? VS_POL : !VS_POL));
    check("frame_cnt", 32'(frame_cnt), 32'(fcnt % (1 << FCNT_W)));
  endtask

  // Drives one clock: strobes checked before the edge, registered outputs after it.
  task automatic cycle(input logic r, input logic e);
    bit le, fe;
    reset  = r;
    pix_en = e;
    #1;
    if (known) begin
      le = e && (pix % HT == HT - 1);
      fe = le && (pix == FRAME - 1);
      check("line_end", 32'(line_end), 32'(le));
      check("frame_end", 32'(frame_end), 32'(fe));
      if (frame_end === 1'b1) fe_seen++;
    end
    @(posedge clk);
    if (r) begin
      pix   = 0;
      fcnt  = 0;
      known = 1;
    end else if (e && known) begin
      if (pix == FRAME - 1) begin
        pix = 0;
        fcnt++;
      end else begin
        pix++;
      end
    end
    #1;
    if (known) check_regs();
  endtask

  initial begin
    // Reset and reach mid-frame, then hold reset for three cycles
    cycle(1'b1, 1'b0);
    for (int i = 0; i < FRAME + 40; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("rst_hpos", 32'(hpos), 32'd0);
    check("rst_vpos", 32'(vpos), 32'd0);
    check("rst_disp", 32'(display_on), 32'd1);
    check("rst_hsync", 32'(hsync), 32'(!HS_POL));
    check("rst_vsync", 32'(vsync), 32'(!VS_POL));
    check("rst_fcnt", 32'(frame_cnt), 32'd0);

    // pix_en 1,0,1,0 straight after reset
    cycle(1'b0, 1'b1); check("toggle_h1", 32'(hpos), 32'd1);
    cycle(1'b0, 1'b0); check("toggle_h2", 32'(hpos), 32'd1);
    cycle(1'b0, 1'b1); check("toggle_h3", 32'(hpos), 32'd2);
    cycle(1'b0, 1'b0); check("toggle_h4", 32'(hpos), 32'd2);

    // Random pixel strobe with occasional reset
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));

    // 256 full frames from reset: frame_cnt must wrap back to zero
    cycle(1'b1, 1'b0);
    fe_seen = 0;
    for (int i = 0; i < 256 * FRAME; i++) cycle(1'b0, 1'b1);
    check("wrap_fe_count", 32'(fe_seen), 32'd256);
    check("wrap_fcnt", 32'(frame_cnt), 32'd0);
    check("wrap_hpos", 32'(hpos), 32'd0);
    check("wrap_vpos", 32'(vpos), 32'd0);

    // Reset coincident with frame_end
    for (int i = 0; i < 2 * FRAME - 1; i++) cycle(1'b0, 1'b1);
    check("pre_fcnt", 32'(frame_cnt), 32'd1);
    check("pre_fe", 32'(frame_end), 32'd1);
    cycle(1'b1, 1'b1);
    check("rfe_fcnt", 32'(frame_cnt), 32'd0);
    check("rfe_hpos", 32'(hpos), 32'd0);
    check("rfe_vpos", 32'(vpos), 32'd0);
    cycle(1'b0, 1'b1);
    check("rfe_no_le", 32'(line_end), 32'd0);
    check("rfe_no_fe", 32'(frame_end), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
